sipo_capture_ctrl: RTL
======================

# sipo_capture_ctrl

Capture sequencer for the serial-in/parallel-out FIFO. Qualifies incoming serial bit strobes, drives the SIPO shift enable for a programmed number of words (or continuously), optionally waits for a frame-sync edge before capturing, and reports completion, word count and overflow. Sits in the SIPO clock domain, between the serial front end and the SIPO `en` input; status is read by software through the existing MMIO block.

## Interface
- `SIPO_WIDTH`, 32: bits per FIFO word; power of two, ≥2.
- `LEN_BITS`, 16: width of word-length config and word counter.
- `clk` input 1: SIPO clock; all logic on rising edge.
- `rstn` input 1: reset, synchronous, active-low.
- `start` input 1: begin capture; sampled only in IDLE.
- `abort` input 1: stop capture; takes priority over everything.
- `cfg_len` input LEN_BITS: words to capture; 0 = continuous until abort.
- `sync` input 1: frame-sync level from front end.
- `bit_strobe` input 1: `sin` carries a valid bit this cycle.
- `fifo_full` input 1: SIPO FIFO full.
- `sipo_en` output 1: shift enable to SIPO.
- `busy` output 1: state ≠ IDLE.
- `done` output 1: one-cycle pulse at end of capture.
- `err` output 1: qualifies `done`; 1 = terminated by overflow.
- `overflow` output 1: sticky; bit strobe arrived while FIFO full.
- `word_cnt` output LEN_BITS: words completed in current/last capture.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- IDLE: `start & ~abort` → clear `bit_cnt`, `word_cnt`, `overflow`; latch `cfg_len` into `len_q`; go ARMED (sync feature in) or CAPTURE (out).
- ARMED: rising edge of `sync` (`sync & ~sync_q`) → CAPTURE. Bit strobes in ARMED are ignored.
- CAPTURE: `sipo_en = bit_strobe & ~fifo_full` (combinational, same cycle as `sin`). Each `sipo_en` increments `bit_cnt` (log2(SIPO_WIDTH) bits, wraps). When `sipo_en` and `bit_cnt == SIPO_WIDTH-1`: `word_cnt++`; if `len_q ≠ 0` and new `word_cnt == len_q` → DONE with `err=0`.
- Overflow: `bit_strobe & fifo_full` in CAPTURE → bit dropped, `overflow` set, → DONE with `err=1`.
- DONE: `done=1` for exactly one cycle, `err` valid same cycle; → IDLE.
- `abort` in ARMED/CAPTURE/DONE → IDLE next cycle, no `done` pulse; `word_cnt` and `overflow` hold.
- `start` outside IDLE ignored. `start & abort` in IDLE: stays IDLE.
- Continuous mode (`len_q == 0`): `word_cnt` wraps at 2^LEN_BITS, capture continues.
- `cfg_len` changes after start have no effect.

## Timing
- Reset values: state IDLE, `sipo_en` 0, `busy` 0, `done` 0, `err` 0, `overflow` 0, `word_cnt` 0, `bit_cnt` 0, `sync_q` 0.
- `rstn` low mid-capture: all of the above next edge; partial word discarded.
- Start→first capturable bit: 1 cycle (no sync); sync-edge cycle +1 (with sync).
- Last bit of final word → `done` pulse next cycle; `busy` low the cycle after.
- `err` and `overflow` change only on the registered edge; `sipo_en` is the only combinational output.

## Configuration
- `SIPO_CAPTURE_SYNC_EN` defined: ARMED state present; capture begins at first `sync` rising edge after start.
- Undefined: ARMED removed, IDLE → CAPTURE directly; `sync` port kept but ignored, `sync_q` not built.

## Structure
- `sipo_pkg`: state enum `sipo_cap_state_t`, default `SIPO_WIDTH`, `LEN_BITS`; shared with the SIPO and MMIO blocks.
- One sub-module: `sync_edge_det` (registered level → one-cycle rising pulse), instantiated only under `SIPO_CAPTURE_SYNC_EN`.
- Everything else flat in `sipo_capture_ctrl`.

## Test plan
- Reset: drive `rstn=0` mid-CAPTURE with strobes active → next cycle all outputs 0, `busy=0`, `sipo_en=0`.
- Length: `SIPO_WIDTH=8`, `cfg_len=3`, strobe every cycle → 24 `sipo_en` pulses, `done=1,err=0` on cycle 25 after entry to CAPTURE, `word_cnt=3`.
- Overflow: `cfg_len=4`, assert `fifo_full` on bit 10 → `sipo_en=0` that cycle, `overflow=1`, `done=1,err=1` next cycle, `word_cnt=1`.
- Sync (macro on): start, strobes for 20 cycles, then `sync` 0→1 → no `sipo_en` before edge; first `sipo_en` cycle after edge.
- Abort/priority: `start&abort` in IDLE → stays IDLE; abort at bit 5 of word 2 → IDLE, no `done`, `word_cnt=1`.
- Continuous: `LEN_BITS=4`, `cfg_len=0`, 17 words → `word_cnt=1`, `busy` still 1, no `done`.

Source files
------------

// File: rtl/sipo_pkg.sv
// ---------------------------------------------------------------------------
// sipo_pkg
// Shared definitions for the SIPO FIFO, its capture sequencer and the MMIO
// status block.
//   SIPO_WIDTH_DEFAULT : default bits per FIFO word (power of two, >= 2)
//   LEN_BITS_DEFAULT   : default width of the word-length config / counter
//   sipo_cap_state_t   : capture sequencer state encoding
// ---------------------------------------------------------------------------
package sipo_pkg;

    localparam int SIPO_WIDTH_DEFAULT = 32;
    localparam int LEN_BITS_DEFAULT   = 16;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_CAPTURE = 2'd2,
        CAP_DONE    = 2'd3
    } sipo_cap_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// ---------------------------------------------------------------------------
// sync_edge_det
// Registers a level and reports its rising edge as a one-cycle pulse.
// Ports:
//   clk   : clock, rising edge
//   rstn  : synchronous active-low reset (registered level clears to 0)
//   level : input level
//   rise  : level & ~level_q, high for the cycle in which level goes 0->1
// ---------------------------------------------------------------------------
module sync_edge_det (
    input  logic clk,
    input  logic rstn,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/sipo_capture_ctrl.sv
// ---------------------------------------------------------------------------
// sipo_capture_ctrl
// Capture sequencer for the serial-in/parallel-out FIFO. Gates serial bit
// strobes into the SIPO shift enable for a programmed number of words (or
// continuously when cfg_len == 0) and reports completion, word count and
// overflow.
//
// Build option: define SIPO_CAPTURE_SYNC_EN to add the ARMED state, in which
// capture waits for the first rising edge of sync after start. Without it the
// sequencer goes straight from IDLE to CAPTURE and sync is ignored.
//
// Ports:
//   clk        : SIPO clock, rising edge
//   rstn       : synchronous active-low reset
//   start      : begin capture (only looked at in IDLE)
//   abort      : stop capture, highest priority, no done pulse
//   cfg_len    : words to capture, latched at start; 0 = continuous
//   sync       : frame-sync level from the front end
//   bit_strobe : sin carries a valid bit this cycle
//   fifo_full  : SIPO FIFO full
//   sipo_en    : shift enable to the SIPO (combinational)
//   busy       : state != IDLE
//   done       : one-cycle pulse at the end of a capture
//   err        : valid with done; 1 = capture ended by overflow
//   overflow   : sticky; a bit strobe arrived while the FIFO was full
//   word_cnt   : words completed in the current/last capture
//   dbg_state  : current sequencer state
//
// Handshake: a bit is consumed in exactly the cycle where sipo_en is high,
// i.e. CAPTURE & bit_strobe & ~fifo_full & ~abort. There is no back-pressure
// toward the front end; a strobe against a full FIFO is dropped and flagged.
// ---------------------------------------------------------------------------
module sipo_capture_ctrl
    import sipo_pkg::*;
#(
    parameter int SIPO_WIDTH = SIPO_WIDTH_DEFAULT,
    parameter int LEN_BITS   = LEN_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    input  logic                abort,
    input  logic [LEN_BITS-1:0] cfg_len,
    input  logic                sync,
    input  logic                bit_strobe,
    input  logic                fifo_full,
    output logic                sipo_en,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                overflow,
    output logic [LEN_BITS-1:0] word_cnt,
    output sipo_cap_state_t     dbg_state
);

    localparam int BIT_W = $clog2(SIPO_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SIPO_WIDTH - 1);

    sipo_cap_state_t     state, state_d;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
    logic [LEN_BITS-1:0] word_cnt_d, word_cnt_inc;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic                overflow_d;
    logic                err_q, err_d;
    logic                sync_rise;

`ifdef SIPO_CAPTURE_SYNC_EN
    sync_edge_det u_sync_edge_det (
        .clk   (clk),
        .rstn  (rstn),
        .level (sync),
        .rise  (sync_rise)
    );
`else
    // Port kept for a stable interface; no edge detector is built.
    logic sync_unused;
    assign sync_unused = sync;
    assign sync_rise   = 1'b0;
`endif

    assign word_cnt_inc = word_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= CAP_IDLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
            len_q    <= '0;
            overflow <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            bit_cnt  <= bit_cnt_d;
            word_cnt <= word_cnt_d;
            len_q    <= len_d;
            overflow <= overflow_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d    = state;
        bit_cnt_d  = bit_cnt;
        word_cnt_d = word_cnt;
        len_d      = len_q;
        overflow_d = overflow;
        err_d      = 1'b0;
        sipo_en    = 1'b0;

        unique case (state)
            CAP_IDLE: begin
                if (start && !abort) begin
                    bit_cnt_d  = '0;
                    word_cnt_d = '0;
                    overflow_d = 1'b0;
                    len_d      = cfg_len;
`ifdef SIPO_CAPTURE_SYNC_EN
                    state_d    = CAP_ARMED;
`else
                    state_d    = CAP_CAPTURE;
`endif
                end
            end

            CAP_ARMED: begin
                // Strobes are ignored until the frame-sync edge.
                if (abort) begin
                    state_d = CAP_IDLE;
                end else if (sync_rise) begin
                    state_d = CAP_CAPTURE;
                end
            end

            CAP_CAPTURE: begin
                if (abort) begin
                    state_d = CAP_IDLE;
                end else if (bit_strobe && fifo_full) begin
                    // Bit dropped: capture ends with an error.
                    overflow_d = 1'b1;
                    err_d      = 1'b1;
                    state_d    = CAP_DONE;
                end else if (bit_strobe) begin
                    sipo_en   = 1'b1;
                    bit_cnt_d = bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        // In continuous mode (len_q == 0) this wraps freely.
                        word_cnt_d = word_cnt_inc;
                        if ((len_q != '0) && (word_cnt_inc == len_q)) begin
                            state_d = CAP_DONE;
                        end
                    end
                end
            end

            CAP_DONE: begin
                state_d = CAP_IDLE;
            end

            default: begin
                state_d = CAP_IDLE;
            end
        endcase
    end

    assign busy      = (state != CAP_IDLE);
    assign done      = (state == CAP_DONE);
    assign err       = err_q;
    assign dbg_state = state;

endmodule
